// File: rtl/microsequencer.sv
// Microsequencer: computes the next microstore address from the current
// microword's next-state control, a selectable branch condition, a
// single-level call/return register and a wait-timeout trap.
module microsequencer #(
    parameter int unsigned TIMEOUT    = 15,
    parameter logic [6:0]  TRAP_STATE = 7'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] ns_ctrl,
    input  logic [1:0] cond_sel,
    input  logic       cond_inv,
    input  logic [6:0] cr,
    input  logic [6:0] enc_state,
    input  logic       moc,
    input  logic       cond_in,
    output logic [6:0] state,
    output logic       waiting,
    output logic       timeout
);

    typedef enum logic [2:0] {
        NS_DISPATCH = 3'b000,
        NS_FETCH    = 3'b001,
        NS_INC      = 3'b010,
        NS_JUMP     = 3'b011,
        NS_BRANCH   = 3'b100,
        NS_WAIT     = 3'b101,
        NS_CALL     = 3'b110,
        NS_RETURN   = 3'b111
    } ns_op_e;

    // Wait-counter value on which the next hold cycle traps instead.
    localparam logic [3:0] TRIP_CNT = 4'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [6:0] state_q, state_d;
    logic [6:0] ret_q, ret_d;
    logic [3:0] wcnt_q, wcnt_d;
    logic       timeout_q, timeout_d;

    logic       cond_src;
    logic       cond;
    logic       hold;
    logic       trap;
    logic [6:0] state_inc;
    ns_op_e     ns_op;

    assign ns_op     = ns_op_e'(ns_ctrl);
    assign state_inc = state_q + 7'd1;    // 7-bit add wraps 127 -> 0

    // Select and optionally invert the branch condition for this cycle.
    always_comb begin
        unique case (cond_sel)
            2'b00:   cond_src = moc;
            2'b01:   cond_src = cond_in;
            2'b10:   cond_src = 1'b0;
            default: cond_src = 1'b1;
        endcase
        cond = cond_src ^ cond_inv;
        hold = (ns_op == NS_WAIT) && !cond;
        trap = hold && (TIMEOUT != 0) && (wcnt_q == TRIP_CNT);
    end

    // Next-state, return-register, wait-counter and trap-flag selection.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        ret_d     = ret_q;
        wcnt_d    = 4'd0;
        timeout_d = timeout_q;

        if (trap) begin
            state_d   = TRAP_STATE;
            timeout_d = 1'b1;
        end else begin
            unique case (ns_op)
                NS_DISPATCH: state_d = enc_state;
                NS_FETCH:    state_d = 7'd0;
                NS_INC:      state_d = state_inc;
                NS_JUMP:     state_d = cr;
                NS_BRANCH:   state_d = cond ? cr : state_inc;
                NS_WAIT: begin
                    if (cond) state_d = state_inc;
                    else      wcnt_d  = wcnt_q + 4'd1;
                end
                NS_CALL: begin
                    ret_d   = state_inc;
                    state_d = cr;
                end
                NS_RETURN:   state_d = ret_q;
            endcase
        end
    end

    // Register all sequencer state; synchronous reset wins over any action.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the values
        // computed before this edge, independent of statement order.
        if (reset) begin
            state_q   <= 7'd0;
            ret_q     <= 7'd0;
            wcnt_q    <= 4'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            wcnt_q    <= wcnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign state   = state_q;
    assign waiting = hold;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for microsequencer: directed scenarios followed by
// randomized microwords, all compared against a behavioural model.
module tb_microsequencer;

    localparam int unsigned TMO  = 15;
    localparam logic [6:0]  TRAP = 7'd99;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] ns_ctrl;
    logic [1:0] cond_sel;
    logic       cond_inv;
    logic [6:0] cr;
    logic [6:0] enc_state;
    logic       moc;
    logic       cond_in;
    logic [6:0] state;
    logic       waiting;
    logic       timeout;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int m_state = 0;
    int m_ret   = 0;
    int m_wcnt  = 0;
    int m_to    = 0;

    microsequencer #(.TIMEOUT(TMO), .TRAP_STATE(TRAP)) dut (
        .clk       (clk),
        .reset     (reset),
        .ns_ctrl   (ns_ctrl),
        .cond_sel  (cond_sel),
        .cond_inv  (cond_inv),
        .cr        (cr),
        .enc_state (enc_state),
        .moc       (moc),
        .cond_in   (cond_in),
        .state     (state),
        .waiting   (waiting),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int m_cond();
        int src;
        case (cond_sel)
            2'd0:    src = int'(moc);
            2'd1:    src = int'(cond_in);
            2'd2:    src = 0;
            default: src = 1;
        endcase
        return src ^ int'(cond_inv);
    endfunction

    function automatic int m_hold();
        return (ns_ctrl == 3'd5 && m_cond() == 0) ? 1 : 0;
    endfunction

    // Apply one clock edge's worth of the sequencing rules to the model.
    task automatic model_edge();
        int nxt;
        int hold;
        nxt  = (m_state + 1) % 128;
        hold = m_hold();
        if (reset) begin
            m_state = 0; m_ret = 0; m_wcnt = 0; m_to = 0;
        end else if (hold == 1 && TMO != 0 && m_wcnt == int'(TMO) - 1) begin
            m_state = int'(TRAP); m_to = 1; m_wcnt = 0;
        end else begin
            case (ns_ctrl)
                3'd0: m_state = int'(enc_state);
                3'd1: m_state = 0;
                3'd2: m_state = nxt;
                3'd3: m_state = int'(cr);
                3'd4: m_state = (m_cond() == 1) ? int'(cr) : nxt;
                3'd5: if (hold == 0) m_state = nxt;
                3'd6: begin m_ret = nxt; m_state = int'(cr); end
                default: m_state = m_ret;
            endcase
            m_wcnt = (hold == 1) ? (m_wcnt + 1) % 16 : 0;
        end
    endtask

    task automatic drive(input logic [2:0] ns, input logic [1:0] sel, input logic inv,
                         input logic [6:0] c, input logic [6:0] enc,
                         input logic m, input logic ci);
        ns_ctrl = ns; cond_sel = sel; cond_inv = inv; cr = c;
        enc_state = enc; moc = m; cond_in = ci;
    endtask

    // One clock: check combinational waiting, take the edge, check registers.
    task automatic cycle(input string tag);
        #1;
        check({tag, "/waiting"}, 32'(waiting), 32'(m_hold()));
        @(posedge clk);
        model_edge();
        #1;
        check({tag, "/state"},   32'(state),      32'(m_state));
        check({tag, "/timeout"}, 32'(timeout),    32'(m_to));
        check({tag, "/wcnt"},    32'(dut.wcnt_q), 32'(m_wcnt));
        check({tag, "/ret"},     32'(dut.ret_q),  32'(m_ret));
    endtask

    initial begin
        reset = 1'b1;
        drive(3'd0, 2'd2, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0);
        cycle("reset");
        cycle("reset2");
        check("reset_state", 32'(state), 32'd0);
        check("reset_timeout", 32'(timeout), 32'd0);
        reset = 1'b0;

        // Increment and wrap
        drive(3'd2, 2'd2, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0);
        cycle("inc1"); check("inc1_abs", 32'(state), 32'd1);
        cycle("inc2"); check("inc2_abs", 32'(state), 32'd2);
        cycle("inc3"); check("inc3_abs", 32'(state), 32'd3);
        drive(3'd3, 2'd2, 1'b0, 7'd127, 7'd0, 1'b0, 1'b0);
        cycle("jmp127"); check("jmp127_abs", 32'(state), 32'd127);
        drive(3'd2, 2'd2, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0);
        cycle("wrap"); check("wrap_abs", 32'(state), 32'd0);

        // Dispatch and fetch
        drive(3'd0, 2'd2, 1'b0, 7'd0, 7'd44, 1'b0, 1'b0);
        cycle("dispatch"); check("dispatch_abs", 32'(state), 32'd44);
        drive(3'd1, 2'd2, 1'b0, 7'd0, 7'd44, 1'b0, 1'b0);
        cycle("fetch"); check("fetch_abs", 32'(state), 32'd0);

        // Conditional branch on cond_in, plain and inverted
        drive(3'd3, 2'd2, 1'b0, 7'd10, 7'd0, 1'b0, 1'b0);
        cycle("jmp10");
        drive(3'd4, 2'd1, 1'b0, 7'd30, 7'd0, 1'b0, 1'b1);
        cycle("br_taken"); check("br_taken_abs", 32'(state), 32'd30);
        drive(3'd3, 2'd2, 1'b0, 7'd10, 7'd0, 1'b0, 1'b0);
        cycle("jmp10b");
        drive(3'd4, 2'd1, 1'b1, 7'd30, 7'd0, 1'b0, 1'b1);
        cycle("br_not"); check("br_not_abs", 32'(state), 32'd11);

        // Wait on moc, then release
        drive(3'd3, 2'd2, 1'b0, 7'd4, 7'd0, 1'b0, 1'b0);
        cycle("jmp4");
        drive(3'd5, 2'd0, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1 check("wait_waiting_abs", 32'(waiting), 32'd1);
            cycle("wait_hold");
            check("wait_hold_abs", 32'(state), 32'd4);
        end
        drive(3'd5, 2'd0, 1'b0, 7'd0, 7'd0, 1'b1, 1'b0);
        cycle("wait_rel");
        check("wait_rel_abs", 32'(state), 32'd5);
        check("wait_rel_wcnt", 32'(dut.wcnt_q), 32'd0);
        check("wait_rel_to", 32'(timeout), 32'd0);

        // Timeout trap at state 2
        drive(3'd3, 2'd2, 1'b0, 7'd2, 7'd0, 1'b0, 1'b0);
        cycle("jmp2");
        drive(3'd5, 2'd0, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) cycle("trap_hold");
        check("trap_hold14_abs", 32'(state), 32'd2);
        check("trap_pre_to", 32'(timeout), 32'd0);
        #1 check("trap_edge_waiting", 32'(waiting), 32'd1);
        cycle("trap");
        check("trap_abs", 32'(state), 32'(TRAP));
        check("trap_to_abs", 32'(timeout), 32'd1);
        // Keep waiting: second trap, flag stays set
        drive(3'd5, 2'd2, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle("trap_again");
        drive(3'd2, 2'd2, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0);
        cycle("sticky"); check("sticky_abs", 32'(timeout), 32'd1);

        // Call / return
        reset = 1'b1; cycle("rst2"); reset = 1'b0;
        check("rst2_to", 32'(timeout), 32'd0);
        drive(3'd7, 2'd2, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0);
        cycle("ret_nocall"); check("ret_nocall_abs", 32'(state), 32'd0);
        drive(3'd3, 2'd2, 1'b0, 7'd20, 7'd0, 1'b0, 1'b0);
        cycle("jmp20");
        drive(3'd6, 2'd2, 1'b0, 7'd50, 7'd0, 1'b0, 1'b0);
        cycle("call"); check("call_abs", 32'(state), 32'd50);
        drive(3'd7, 2'd2, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0);
        cycle("return"); check("return_abs", 32'(state), 32'd21);
        drive(3'd6, 2'd2, 1'b0, 7'd70, 7'd0, 1'b0, 1'b0);
        cycle("call2");
        drive(3'd6, 2'd2, 1'b0, 7'd90, 7'd0, 1'b0, 1'b0);
        cycle("call3"); check("call3_ret_abs", 32'(dut.ret_q), 32'd71);
        reset = 1'b1;
        drive(3'd6, 2'd2, 1'b0, 7'd50, 7'd0, 1'b0, 1'b0);
        cycle("rst_call");
        check("rst_call_state", 32'(state), 32'd0);
        check("rst_call_ret", 32'(dut.ret_q), 32'd0);
        reset = 1'b0;
        drive(3'd2, 2'd2, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0);
        cycle("post_rst"); check("post_rst_abs", 32'(state), 32'd1);

        // Randomized microwords
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            drive(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            // Occasionally a long wait burst to reach the trap
            if ($urandom_range(0, 49) == 0) begin
                drive(3'd5, 2'd2, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0);
                for (int k = 0; k < 18; k++) cycle("rand_burst");
            end else begin
                cycle("rand");
            end
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/microsequencer.md
MICROSEQUENCER -- requirements
Module: microsequencer

Interface
REQ-001 Parameter TIMEOUT, default 15, number of consecutive wait-hold cycles before a trap; 0 disables the trap.
REQ-002 Parameter TRAP_STATE, default 7'd0, the state entered on wait timeout.
REQ-003 clk  input  1  rising-edge clock for all registers.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 ns_ctrl  input  3  next-state control field (N2..N0) from the microstore word of the current state.
REQ-006 cond_sel  input  2  condition select: 00 moc, 01 cond_in, 10 constant 0, 11 constant 1.
REQ-007 cond_inv  input  1  inverts the selected condition.
REQ-008 cr  input  7  branch, jump or call target field from the microstore word.
REQ-009 enc_state  input  7  dispatch state from the instruction encoder.
REQ-010 moc  input  1  memory operation complete.
REQ-011 cond_in  input  1  datapath branch condition.
REQ-012 state  output  7  current state, registered, drives the microstore address.
REQ-013 waiting  output  1  combinational: 1 while ns_ctrl=101 and cond=0.
REQ-014 timeout  output  1  sticky trap flag, registered.

Function
REQ-015 cond SHALL be the selected source XOR cond_inv, evaluated combinationally in the current cycle.
REQ-016 state SHALL update only on a rising clk edge; next-state selection is combinational from the current-cycle inputs.
REQ-017 ns_ctrl 000 (dispatch): next state SHALL be enc_state.
REQ-018 ns_ctrl 001 (fetch): next state SHALL be 7'd0.
REQ-019 ns_ctrl 010 (increment): next state SHALL be state+1, modulo 128 (7'd127 wraps to 7'd0).
REQ-020 ns_ctrl 011 (jump): next state SHALL be cr.
REQ-021 ns_ctrl 100 (conditional branch): next state SHALL be cr if cond=1, else state+1 modulo 128.
REQ-022 ns_ctrl 101 (conditional wait), cond=1: next state SHALL be state+1 modulo 128.
REQ-023 ns_ctrl 101, cond=0: state SHALL hold (a hold cycle), unless REQ-027 applies.
REQ-024 ns_ctrl 110 (call): return register ret SHALL load state+1 modulo 128; next state SHALL be cr.
REQ-025 ns_ctrl 111 (return): next state SHALL be ret; ret is unchanged.
REQ-026 Wait counter wcnt (4 bits): SHALL increment on each hold cycle; SHALL clear to 0 on any cycle that is not a hold cycle.
REQ-027 Trap: if TIMEOUT!=0, a hold cycle occurs and wcnt==TIMEOUT-1, then next state SHALL be TRAP_STATE, timeout SHALL set to 1, and wcnt SHALL clear.
REQ-028 timeout SHALL stay 1 until reset; further traps leave it at 1.
REQ-029 A call executed while ret already holds a value SHALL overwrite ret (single level, no nesting).
REQ-030 A return with no prior call since reset SHALL go to ret's reset value, 7'd0.
REQ-031 waiting SHALL be 1 during a hold cycle, including the cycle that triggers the trap.

Reset
REQ-032 When reset=1 at a clk edge: state SHALL go to 7'd0; ret, wcnt and timeout SHALL go to 0.
REQ-033 Reset SHALL take priority over every ns_ctrl action, including a call, a trap, or a wait in progress; no partial update of ret is permitted.
REQ-034 In the first cycle after reset is released, state SHALL be 7'd0 and normal sequencing SHALL resume from the inputs of that cycle.

Verification
REQ-035 Reset, then ns_ctrl=010 for 3 cycles -> state 0,1,2,3; force state 127 via a jump with cr=127, then ns_ctrl=010 -> state 0.
REQ-036 ns_ctrl=000 with enc_state=7'd44 -> state 44 next cycle; ns_ctrl=001 -> state 0.
REQ-037 At state 10: ns_ctrl=100, cond_sel=01, cond_in=1, cond_inv=0, cr=30 -> state 30; repeat with cond_inv=1 -> state 11.
REQ-038 At state 4: ns_ctrl=101, cond_sel=00, moc=0 for 3 cycles -> state stays 4 and waiting=1; moc=1 -> state 5, wcnt=0, timeout=0.
REQ-039 TIMEOUT=15, moc held 0 in wait at state 2 -> state 2 for 14 edges, TRAP_STATE on the 15th edge, timeout=1 until reset.
REQ-040 At state 20: call with cr=50 -> state 50; return -> state 21; assert reset during a call edge -> state 0, ret 0.
